// File: rtl/genius_fluxo_dados_n_pkg.sv
// Shared definitions for the sequence-memory game datapath: LFSR step,
// one-hot helper and button-count legality check.
package genius_pkg;

    localparam logic [15:0] LFSR_SEED_PADRAO = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    function automatic logic [15:0] lfsr_prox(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic bit nbot_ok(input int n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/genius_fluxo_dados_n_contador_sat.sv
// Saturating up-timer: clears on reset/zera, counts while conta, holds at M-1.
// fim flags the terminal value, acima flags values at or beyond N-1.
module contador_sat #(
    parameter int M = 5000,
    parameter int N = M
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim,
    output logic acima
);
    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] valor;

    always_ff @(posedge clock) begin
        if (reset || zera)
            valor <= '0;
        else if (conta && !fim)
            valor <= valor + 1'b1;
    end

    assign fim   = (valor == W'(M - 1));
    assign acima = (valor >= W'(N - 1));

endmodule

// File: rtl/genius_fluxo_dados_n.sv
// Datapath for the sequence-memory game: play memory, address/round counters,
// timers, button edge detection and an LFSR source for random plays.
module genius_fluxo_dados_n
    import genius_pkg::*;
#(
    parameter int          NBOT        = 4,
    parameter int          DEPTH       = 16,
    parameter int          AW          = $clog2(DEPTH),
    parameter int          TIMEOUT_CYC = 5000,
    parameter int          LED_ON_CYC  = 2000,
    parameter int          LED_CURTO   = 500,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_PADRAO
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            zeraE,
    input  logic            contaE,
    input  logic            zeraR,
    input  logic            contaR,
    input  logic            zeraT,
    input  logic            contaT,
    input  logic            zeraL,
    input  logic            contaL,
    input  logic            limpaJ,
    input  logic            registraJ,
    input  logic            zeraLeds,
    input  logic            registraLeds,
    input  logic            led_sel,
    input  logic            led_apaga,
    input  logic            escreveM,
    input  logic            gera_aleatorio,
    input  logic [NBOT-1:0] botoes,
    output logic            jogada_correta,
    output logic            endereco_igual_rodada,
    output logic            fim_endereco,
    output logic            fim_rodada,
    output logic            jogada_feita,
    output logic            jogada_valida,
    output logic            timeout,
    output logic            led_curto,
    output logic            led_fim,
    output logic [NBOT-1:0] leds,
    output logic [AW-1:0]   db_endereco,
    output logic [AW-1:0]   db_rodada,
    output logic [NBOT-1:0] db_jogada,
    output logic [NBOT-1:0] db_memoria
);
    localparam int SW = $clog2(NBOT);

    if (!nbot_ok(NBOT)) begin : g_nbot_invalido
        $error("NBOT must be 2, 4 or 8");
    end

    logic [AW-1:0]   endereco, rodada;
    logic [NBOT-1:0] jogada, b_r, dado_escrita;
    logic            b_d, sel_r, t_fim, t_acima;
    logic [15:0]     lfsr;
    logic [NBOT-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= '0;
            rodada   <= '0;
            jogada   <= '0;
            sel_r    <= 1'b0;
            b_r      <= '0;
            b_d      <= 1'b0;
            lfsr     <= LFSR_SEED;
        end else begin
            if (zeraE)
                endereco <= '0;
            else if (contaE)
                endereco <= (endereco == AW'(DEPTH - 1)) ? '0 : endereco + 1'b1;
            if (zeraR)
                rodada <= '0;
            else if (contaR)
                rodada <= (rodada == AW'(DEPTH - 1)) ? '0 : rodada + 1'b1;
            if (limpaJ)
                jogada <= '0;
            else if (registraJ)
                jogada <= b_r;
            if (zeraLeds)
                sel_r <= 1'b0;
            else if (registraLeds)
                sel_r <= led_sel;
            b_r  <= botoes;
            b_d  <= |b_r;
            lfsr <= lfsr_prox(lfsr);
        end
    end

    // Memory is deliberately left out of reset so the stored sequence survives it.
    always_ff @(posedge clock) begin
        if (escreveM)
            mem[endereco] <= dado_escrita;
    end

    assign dado_escrita = gera_aleatorio ? NBOT'(onehot(3'(lfsr[SW-1:0]))) : jogada;

    contador_sat #(.M(TIMEOUT_CYC), .N(TIMEOUT_CYC)) u_timer_t (
        .clock (clock),
        .reset (reset),
        .zera  (zeraT),
        .conta (contaT),
        .fim   (t_fim),
        .acima (t_acima)
    );

    contador_sat #(.M(LED_ON_CYC), .N(LED_CURTO)) u_timer_l (
        .clock (clock),
        .reset (reset),
        .zera  (zeraL),
        .conta (contaL),
        .fim   (led_fim),
        .acima (led_curto)
    );

    assign timeout               = t_fim & t_acima;
    assign db_memoria            = mem[endereco];
    assign db_endereco           = endereco;
    assign db_rodada             = rodada;
    assign db_jogada             = jogada;
    assign jogada_correta        = (db_memoria == jogada);
    assign endereco_igual_rodada = (endereco == rodada);
    assign fim_endereco          = (endereco == AW'(DEPTH - 1));
    assign fim_rodada            = (rodada == AW'(DEPTH - 1));
    assign jogada_feita          = (|b_r) & ~b_d;
    assign jogada_valida         = ($countones(b_r) == 1);
    assign leds                  = sel_r ? db_memoria : (led_apaga ? '0 : jogada);

endmodule

// File: tb/tb_genius_fluxo_dados_n.sv
// Directed bench for genius_fluxo_dados_n: vector table for counters/buttons/play
// register, plus hand sequences for wrap, memory, LEDs, timers, LFSR and reset.
module tb_genius_fluxo_dados_n;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraE, contaE, zeraR, contaR, zeraT, contaT, zeraL, contaL;
    logic       limpaJ, registraJ, zeraLeds, registraLeds, led_sel, led_apaga;
    logic       escreveM, gera_aleatorio;
    logic [3:0] botoes;
    logic       jogada_correta, endereco_igual_rodada, fim_endereco, fim_rodada;
    logic       jogada_feita, jogada_valida, timeout, led_curto, led_fim;
    logic [3:0] leds, db_endereco, db_rodada, db_jogada, db_memoria;

    int checks = 0;
    int failures = 0;

    genius_fluxo_dados_n dut (
        .clock(clock), .reset(reset),
        .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR),
        .zeraT(zeraT), .contaT(contaT), .zeraL(zeraL), .contaL(contaL),
        .limpaJ(limpaJ), .registraJ(registraJ),
        .zeraLeds(zeraLeds), .registraLeds(registraLeds),
        .led_sel(led_sel), .led_apaga(led_apaga),
        .escreveM(escreveM), .gera_aleatorio(gera_aleatorio), .botoes(botoes),
        .jogada_correta(jogada_correta), .endereco_igual_rodada(endereco_igual_rodada),
        .fim_endereco(fim_endereco), .fim_rodada(fim_rodada),
        .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
        .timeout(timeout), .led_curto(led_curto), .led_fim(led_fim), .leds(leds),
        .db_endereco(db_endereco), .db_rodada(db_rodada),
        .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

    always #5 clock = ~clock;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic       contaE, zeraE, contaR, zeraR, registraJ, limpaJ;
        logic [3:0] botoes;
        logic [3:0] e, r;
        logic       feita, valida;
        logic [3:0] jog;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] pass1[16];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle();
        zeraE = 0; contaE = 0; zeraR = 0; contaR = 0; zeraT = 0; contaT = 0;
        zeraL = 0; contaL = 0; limpaJ = 0; registraJ = 0; zeraLeds = 0;
        registraLeds = 0; led_sel = 0; led_apaga = 0; escreveM = 0;
        gera_aleatorio = 0; botoes = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic write_random_16();
        for (int i = 0; i < 16; i++) begin
            escreveM = 1; gera_aleatorio = 1;
            pass1[i] = (i >= 0) ? (4'b0001 << m_lfsr[1:0]) : 4'h0;
            tick();
            escreveM = 0; gera_aleatorio = 0; contaE = 1;
            tick();
            contaE = 0;
        end
    endtask

    initial begin
        idle();
        reset = 1;
        ticks(2);
        reset = 0;

        chk("rst_endereco", 32'(db_endereco), 0);
        chk("rst_rodada", 32'(db_rodada), 0);
        chk("rst_feita", 32'(jogada_feita), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_jogada", 32'(db_jogada), 0);
        chk("rst_led_curto", 32'(led_curto), 0);

        // contaE zeraE contaR zeraR regJ limpaJ botoes | e r feita valida jog
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd1, 4'd0, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4'd2, 4'd1, 1'b1, 1'b1, 4'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd0, 4'd1, 1'b0, 1'b1, 4'h4};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 4'd0, 4'd2, 1'b0, 1'b0, 4'h4};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd0, 4'd2, 1'b0, 1'b0, 4'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'd0, 4'd2, 1'b1, 1'b1, 4'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'd0, 4'd0, 1'b0, 1'b1, 4'h1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 4'd1, 4'd0, 1'b0, 1'b1, 4'h1};

        for (int i = 0; i < 8; i++) begin
            contaE = vecs[i].contaE; zeraE = vecs[i].zeraE;
            contaR = vecs[i].contaR; zeraR = vecs[i].zeraR;
            registraJ = vecs[i].registraJ; limpaJ = vecs[i].limpaJ;
            botoes = vecs[i].botoes;
            tick();
            chk($sformatf("vec%0d_endereco", i), 32'(db_endereco), 32'(vecs[i].e));
            chk($sformatf("vec%0d_rodada", i), 32'(db_rodada), 32'(vecs[i].r));
            chk($sformatf("vec%0d_feita", i), 32'(jogada_feita), 32'(vecs[i].feita));
            chk($sformatf("vec%0d_valida", i), 32'(jogada_valida), 32'(vecs[i].valida));
            chk($sformatf("vec%0d_jogada", i), 32'(db_jogada), 32'(vecs[i].jog));
        end
        idle();

        // Counter wrap
        do_reset();
        contaE = 1; contaR = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 14) chk("wrap_fim_e_at14", 32'(fim_endereco), 0);
        end
        chk("wrap_end15", 32'(db_endereco), 15);
        chk("wrap_fim_e", 32'(fim_endereco), 1);
        chk("wrap_fim_r", 32'(fim_rodada), 1);
        chk("wrap_igual", 32'(endereco_igual_rodada), 1);
        tick();
        chk("wrap_end0", 32'(db_endereco), 0);
        chk("wrap_rod0", 32'(db_rodada), 0);
        chk("wrap_fim_e_off", 32'(fim_endereco), 0);
        contaE = 0;
        ticks(3);
        chk("rod3", 32'(db_rodada), 3);
        chk("igual_off", 32'(endereco_igual_rodada), 0);
        idle();

        // Press strobe: held 5 cycles, one-cycle pulse right after sampling
        do_reset();
        begin
            int highs = 0;
            botoes = 4'b0100;
            for (int i = 1; i <= 5; i++) begin
                tick();
                if (jogada_feita) highs++;
                if (i == 1) chk("strobe_first", 32'(jogada_feita), 1);
                chk($sformatf("strobe_valida%0d", i), 32'(jogada_valida), 1);
            end
            chk("strobe_count", 32'(highs), 1);
            botoes = 4'b0110;
            tick();
            chk("two_buttons_valida", 32'(jogada_valida), 0);
        end
        idle();

        // Memory write/read at address 3, LED source selection
        do_reset();
        contaE = 1; ticks(3); contaE = 0;
        botoes = 4'b0100; tick();
        registraJ = 1; tick(); registraJ = 0;
        escreveM = 1; tick(); escreveM = 0;
        chk("mem_addr", 32'(db_endereco), 3);
        chk("mem_rd", 32'(db_memoria), 32'h4);
        chk("mem_correta", 32'(jogada_correta), 1);
        contaE = 1; tick(); contaE = 0;
        zeraE = 1; tick(); zeraE = 0;
        contaE = 1; ticks(3); contaE = 0;
        chk("mem_reread", 32'(db_memoria), 32'h4);
        chk("mem_reread_ok", 32'(jogada_correta), 1);
        botoes = 4'b0001; tick();
        registraJ = 1; tick(); registraJ = 0;
        chk("mem_incorreta", 32'(jogada_correta), 0);
        led_sel = 1; registraLeds = 1; tick(); registraLeds = 0;
        chk("leds_mem", 32'(leds), 32'h4);
        led_sel = 0; registraLeds = 1; led_apaga = 1; tick(); registraLeds = 0;
        chk("leds_apaga", 32'(leds), 0);
        led_apaga = 0; #1;
        chk("leds_jogada", 32'(leds), 32'h1);
        led_sel = 1; registraLeds = 1; tick(); registraLeds = 0; led_sel = 0;
        zeraLeds = 1; tick(); zeraLeds = 0;
        chk("leds_zera", 32'(leds), 32'h1);
        escreveM = 1; #1;
        chk("rdw_old", 32'(db_memoria), 32'h4);
        tick(); escreveM = 0;
        chk("rdw_new", 32'(db_memoria), 32'h1);
        chk("rdw_correta", 32'(jogada_correta), 1);
        idle();

        // Timeout timer: terminal after 4999 counts, saturates, zeraT wins
        do_reset();
        contaT = 1;
        ticks(4998);
        chk("timeout_before", 32'(timeout), 0);
        tick();
        chk("timeout_rise", 32'(timeout), 1);
        ticks(10);
        chk("timeout_hold", 32'(timeout), 1);
        zeraT = 1; tick(); zeraT = 0;
        chk("timeout_zera", 32'(timeout), 0);
        idle();

        // LED timer
        contaL = 1;
        ticks(498);
        chk("curto_before", 32'(led_curto), 0);
        tick();
        chk("curto_rise", 32'(led_curto), 1);
        ticks(1499);
        chk("led_fim_before", 32'(led_fim), 0);
        tick();
        chk("led_fim_rise", 32'(led_fim), 1);
        ticks(5);
        chk("led_fim_hold", 32'(led_fim), 1);
        chk("curto_hold", 32'(led_curto), 1);
        idle();

        // LFSR fill, then repeat after reset
        do_reset();
        write_random_16();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rnd_word%0d", i), 32'(db_memoria), 32'(pass1[i]));
            chk($sformatf("rnd_onehot%0d", i), 32'($countones(db_memoria)), 1);
            contaE = 1; tick(); contaE = 0;
        end
        begin
            logic [3:0] first[16];
            for (int i = 0; i < 16; i++) first[i] = pass1[i];
            do_reset();
            write_random_16();
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("rnd_repeat%0d", i), 32'(db_memoria), 32'(first[i]));
                contaE = 1; tick(); contaE = 0;
            end
        end
        idle();

        // Reset mid-round drops everything including a pending strobe
        do_reset();
        contaE = 1; contaR = 1; contaT = 1; contaL = 1;
        ticks(600);
        botoes = 4'b0010;
        tick();
        chk("pre_rst_feita", 32'(jogada_feita), 1);
        chk("pre_rst_curto", 32'(led_curto), 1);
        reset = 1;
        tick();
        reset = 0;
        idle();
        chk("mid_rst_endereco", 32'(db_endereco), 0);
        chk("mid_rst_rodada", 32'(db_rodada), 0);
        chk("mid_rst_feita", 32'(jogada_feita), 0);
        chk("mid_rst_curto", 32'(led_curto), 0);
        chk("mid_rst_leds", 32'(leds), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
